// File: rtl/debug_unit_mbp.sv
// ============================================================================
// debug_unit_mbp : per-core debug controller with NBP hardware PC breakpoints,
//                  single-step, stop-cause register and debug j7 opcodes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module debug_unit_mbp #(
  parameter int PC_W      = 31,
  parameter int CORE_W    = 4,
  parameter int NBP       = 4,
  parameter int SEL_W     = (NBP > 1) ? $clog2(NBP) : 1,
  parameter int SAVE_BASE = 32,
  parameter int DBG_SRC   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       link_i,
  input  logic [PC_W-1:0]   PC_i,
  input  logic              instrValid_i,
  input  logic [CORE_W-1:0] whichCore_i,
  input  logic              j7valid_i,
  input  logic [3:0]        opcode_i,
  input  logic [31:0]       wdata_i,
  input  logic [SEL_W-1:0]  wsel_i,
  input  logic              rqe_i,
  input  logic              ctrlValid_i,
  input  logic [3:0]        ctrlSrc_i,
  input  logic [3:0]        ctrlType_i,
  input  logic              stopOK_i,
  output logic              loadLink_o,
  output logic [31:0]       linkValue_o,
  output logic              zeroPCsetNullify_o,
  output logic              emptyAWqueues_o,
  output logic              running_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    STEP     = 2'd3
  } state_t;

  localparam logic [2:0] c_CAUSE_BREAK = 3'd1;
  localparam logic [2:0] c_CAUSE_HWBP  = 3'd2;
  localparam logic [2:0] c_CAUSE_STOP  = 3'd3;
  localparam logic [2:0] c_CAUSE_KILL  = 3'd4;
  localparam logic [2:0] c_CAUSE_STEP  = 3'd5;

  state_t              state_q, state_d;
  logic [2:0]          cause_q, cause_d;
  logic                step_arm_q, step_arm_d;
  logic [PC_W-1:0]     saved_pc_q;
  logic [31:0]         saved_link_q;
  logic [NBP-1:0]      bp_en_q;
  logic [PC_W-1:0]     bp_addr_q [NBP];

  logic                w_msg_start, w_msg_stop, w_msg_kill, w_msg_step;
  logic                w_active, w_kill, w_brk, w_bp_hit, w_stop_done, w_step_done;
  logic                w_to_idle, w_sel_ok, w_ll;
  logic [NBP-1:0]      w_match;
  logic [31:0]         w_lv, w_save_area;

  assign w_msg_start = ctrlValid_i && (ctrlSrc_i == 4'(DBG_SRC)) && (ctrlType_i == 4'd0);
  assign w_msg_stop  = ctrlValid_i && (ctrlSrc_i == 4'(DBG_SRC)) && (ctrlType_i == 4'd1);
  assign w_msg_kill  = ctrlValid_i && (ctrlSrc_i == 4'(DBG_SRC)) && (ctrlType_i == 4'd2);
  assign w_msg_step  = ctrlValid_i && (ctrlSrc_i == 4'(DBG_SRC)) && (ctrlType_i == 4'd3);

  generate
    for (genvar i = 0; i < NBP; i++) begin : g_bp
      assign w_match[i] = bp_en_q[i] && (PC_i == bp_addr_q[i]);
    end
  endgenerate

  assign w_active    = (state_q != IDLE);
  assign w_kill      = w_active && w_msg_kill;
  assign w_brk       = w_active && j7valid_i && (opcode_i == 4'd6);
  assign w_bp_hit    = (state_q == RUN) && instrValid_i && (|w_match);
  assign w_stop_done = (state_q == STOPPING) && stopOK_i;
  assign w_step_done = (state_q == STEP) && step_arm_q && instrValid_i;
  assign w_sel_ok    = (int'(wsel_i) < NBP);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    step_arm_d = step_arm_q;
    w_to_idle  = 1'b0;
    if (w_kill) begin
      w_to_idle = 1'b1;
      cause_d   = c_CAUSE_KILL;
    end else if (w_brk) begin
      w_to_idle = 1'b1;
      cause_d   = c_CAUSE_BREAK;
    end else if (w_bp_hit) begin
      w_to_idle = 1'b1;
      cause_d   = c_CAUSE_HWBP;
    end else if (w_stop_done) begin
      w_to_idle = 1'b1;
      cause_d   = c_CAUSE_STOP;
    end else if (w_step_done) begin
      w_to_idle = 1'b1;
      cause_d   = c_CAUSE_STEP;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_msg_start) begin
            state_d = RUN;
          end else if (w_msg_step) begin
            state_d    = STEP;
            step_arm_d = 1'b0;
          end
        end
        RUN:      if (w_msg_stop) state_d = STOPPING;
        STEP:     if (instrValid_i) step_arm_d = 1'b1;
        default:  ;
      endcase
    end
    if (w_to_idle) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cause_q      <= 3'd0;
      step_arm_q   <= 1'b0;
      saved_pc_q   <= '0;
      saved_link_q <= '0;
      bp_en_q      <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      step_arm_q <= step_arm_d;
      if (w_to_idle) begin
        saved_pc_q   <= PC_i;
        saved_link_q <= link_i;
      end
      if (j7valid_i && w_sel_ok && (opcode_i == 4'd8)) bp_en_q[wsel_i] <= 1'b1;
      if (j7valid_i && w_sel_ok && (opcode_i == 4'd9)) bp_en_q[wsel_i] <= 1'b0;
    end
  end

  // Addresses carry no reset: they only matter once the matching enable is set.
  always_ff @(posedge clock) begin
    if (j7valid_i && w_sel_ok && (opcode_i == 4'd8)) bp_addr_q[wsel_i] <= wdata_i[PC_W-1:0];
  end

  assign w_save_area = (32'(SAVE_BASE) + 32'(whichCore_i)) << 9;

  always_comb begin
    w_ll = 1'b1;
    w_lv = 32'd0;
    case (opcode_i)
      4'd1:    w_lv = w_save_area;
      4'd2:    w_lv = 32'(saved_pc_q);
      4'd3:    w_lv = saved_link_q;
      4'd4:    w_lv = {31'd0, ~rqe_i};
      4'd5:    w_lv = {31'd0, running_o};
      4'd7:    w_lv = {28'd0, |bp_en_q, cause_q};
      4'd10:   w_lv = 32'(bp_en_q);
      default: w_ll = 1'b0;
    endcase
    if (!j7valid_i) w_ll = 1'b0;
  end

  assign loadLink_o         = w_ll;
  assign linkValue_o        = w_ll ? w_lv : 32'd0;
  assign zeroPCsetNullify_o = w_to_idle && !reset;
  assign emptyAWqueues_o    = w_kill && !reset;
  assign running_o          = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_debug_unit_mbp.sv
// ============================================================================
// tb_debug_unit_mbp : directed vector table plus hand sequences for debug_unit_mbp.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_debug_unit_mbp;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] link;
  logic [30:0] pc;
  logic        instr_valid;
  logic [3:0]  which_core;
  logic        j7valid;
  logic [3:0]  opcode;
  logic [31:0] wdata;
  logic [1:0]  wsel;
  logic        rqe;
  logic        ctrl_valid;
  logic [3:0]  ctrl_src;
  logic [3:0]  ctrl_type;
  logic        stop_ok;
  logic        load_link;
  logic [31:0] link_value;
  logic        zpn;
  logic        eaw;
  logic        running;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  debug_unit_mbp dut (
    .clock              (clock),
    .reset              (reset),
    .link_i             (link),
    .PC_i               (pc),
    .instrValid_i       (instr_valid),
    .whichCore_i        (which_core),
    .j7valid_i          (j7valid),
    .opcode_i           (opcode),
    .wdata_i            (wdata),
    .wsel_i             (wsel),
    .rqe_i              (rqe),
    .ctrlValid_i        (ctrl_valid),
    .ctrlSrc_i          (ctrl_src),
    .ctrlType_i         (ctrl_type),
    .stopOK_i           (stop_ok),
    .loadLink_o         (load_link),
    .linkValue_o        (link_value),
    .zeroPCsetNullify_o (zpn),
    .emptyAWqueues_o    (eaw),
    .running_o          (running)
  );

  typedef struct {
    logic        cv;
    logic [3:0]  src;
    logic [3:0]  typ;
    logic        j7;
    logic [3:0]  op;
    logic [31:0] wd;
    logic [1:0]  ws;
    logic        iv;
    logic [30:0] pc;
    logic        sok;
    logic        rqe;
    logic [31:0] lnk;
    logic [3:0]  core;
    logic        e_ll;
    logic [31:0] e_lv;
    logic        e_zpn;
    logic        e_eaw;
    logic        e_run;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic cv, input logic [3:0] typ, input logic j7, input logic [3:0] op,
                     input logic iv, input logic [30:0] pca, input logic sok,
                     input logic e_ll, input logic [31:0] e_lv, input logic e_zpn,
                     input logic e_eaw, input logic e_run,
                     input logic [3:0] src = 4'd1, input logic [31:0] wd = 32'd0,
                     input logic [1:0] ws = 2'd0, input logic rq = 1'b1,
                     input logic [31:0] lnk = 32'd0, input logic [3:0] core = 4'd0);
    vec_t r;
    r.cv = cv; r.src = src; r.typ = typ; r.j7 = j7; r.op = op; r.wd = wd; r.ws = ws;
    r.iv = iv; r.pc = pca; r.sok = sok; r.rqe = rq; r.lnk = lnk; r.core = core;
    r.e_ll = e_ll; r.e_lv = e_lv; r.e_zpn = e_zpn; r.e_eaw = e_eaw; r.e_run = e_run;
    tbl.push_back(r);
  endtask

  task automatic idle_inputs();
    link = 0; pc = 0; instr_valid = 0; which_core = 0; j7valid = 0; opcode = 0;
    wdata = 0; wsel = 0; rqe = 1; ctrl_valid = 0; ctrl_src = 4'd1; ctrl_type = 0; stop_ok = 0;
  endtask

  task automatic apply(input vec_t r);
    ctrl_valid = r.cv; ctrl_src = r.src; ctrl_type = r.typ; j7valid = r.j7; opcode = r.op;
    wdata = r.wd; wsel = r.ws; instr_valid = r.iv; pc = r.pc; stop_ok = r.sok; rqe = r.rqe;
    link = r.lnk; which_core = r.core;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic e_ll, input logic [31:0] e_lv,
                            input logic e_zpn, input logic e_eaw, input logic e_run);
    n_vec++;
    chk({nm, " loadLink"}, 32'(load_link), 32'(e_ll));
    chk({nm, " linkValue"}, link_value, e_lv);
    chk({nm, " zeroPCsetNullify"}, 32'(zpn), 32'(e_zpn));
    chk({nm, " emptyAWqueues"}, 32'(eaw), 32'(e_eaw));
    chk({nm, " running"}, 32'(running), 32'(e_run));
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs are checked 1ns later.
  task automatic step_cycle();
    @(negedge clock);
    idle_inputs();
  endtask

  initial begin
    bit seen;
    //  cv typ j7 op iv pc      sok  ll lv            zpn eaw run  extras
    add(0, 0, 1, 5, 0, 0,      0,   1, 0,            0,  0,  0);                   // 0 idle read running
    add(1, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  0);                   // 1 start
    add(0, 0, 1, 5, 0, 0,      0,   1, 1,            0,  0,  1);                   // 2
    add(0, 0, 1, 1, 0, 0,      0,   1, 32'h4600,     0,  0,  1, 1, 0, 0, 1, 0, 3); // 3 save area core 3
    add(0, 0, 1, 4, 0, 0,      0,   1, 1,            0,  0,  1, 1, 0, 0, 0);       // 4 rqe low
    add(0, 0, 1, 8, 0, 0,      0,   0, 0,            0,  0,  1, 1, 32'h40, 2);     // 5 setBP slot 2
    add(0, 0, 1, 10, 0, 0,     0,   1, 4,            0,  0,  1);                   // 6
    add(0, 0, 0, 0, 1, 'h3C,   0,   0, 0,            0,  0,  1);                   // 7
    add(0, 0, 0, 0, 1, 'h40,   0,   0, 0,            1,  0,  1, 1, 0, 0, 1, 32'h1234); // 8 bp hit
    add(0, 0, 1, 2, 0, 0,      0,   1, 32'h40,       0,  0,  0);                   // 9
    add(0, 0, 1, 7, 0, 0,      0,   1, 32'hA,        0,  0,  0);                   // 10
    add(0, 0, 1, 3, 0, 0,      0,   1, 32'h1234,     0,  0,  0);                   // 11
    add(1, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  0, 2);                // 12 wrong source
    add(0, 0, 1, 5, 0, 0,      0,   1, 0,            0,  0,  0);                   // 13
    add(1, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  0);                   // 14 start
    add(1, 1, 0, 0, 0, 0,      0,   0, 0,            0,  0,  1);                   // 15 stop
    add(0, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  1);                   // 16..20 stopOK low
    add(1, 1, 0, 0, 0, 0,      0,   0, 0,            0,  0,  1);
    add(0, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  1);
    add(0, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  1);
    add(0, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  1);
    add(0, 0, 0, 0, 0, 0,      1,   0, 0,            1,  0,  1);                   // 21 stop completes
    add(0, 0, 1, 7, 0, 0,      0,   1, 32'hB,        0,  0,  0);                   // 22
    add(1, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  0);                   // 23 start
    add(1, 1, 0, 0, 0, 0,      0,   0, 0,            0,  0,  1);                   // 24 stop
    add(1, 2, 0, 0, 0, 0,      0,   0, 0,            1,  1,  1);                   // 25 kill
    add(0, 0, 1, 7, 0, 0,      0,   1, 32'hC,        0,  0,  0);                   // 26
    add(1, 2, 0, 0, 0, 0,      0,   0, 0,            0,  0,  0);                   // 27 kill in idle
    add(1, 3, 0, 0, 0, 0,      0,   0, 0,            0,  0,  0);                   // 28 step
    add(0, 0, 0, 0, 1, 'h100,  0,   0, 0,            0,  0,  1);                   // 29 arm
    add(0, 0, 0, 0, 1, 'h104,  0,   0, 0,            1,  0,  1);                   // 30 step done
    add(0, 0, 0, 0, 1, 'h108,  0,   0, 0,            0,  0,  0);                   // 31
    add(0, 0, 1, 7, 0, 0,      0,   1, 32'hD,        0,  0,  0);                   // 32
    add(0, 0, 1, 2, 0, 0,      0,   1, 32'h104,      0,  0,  0);                   // 33
    add(1, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  0);                   // 34 start
    add(0, 0, 1, 5, 0, 0,      0,   1, 1,            0,  0,  1);                   // 35
    add(0, 0, 1, 6, 1, 'h40,   0,   0, 0,            1,  0,  1);                   // 36 break + bp hit
    add(0, 0, 1, 7, 0, 0,      0,   1, 32'h9,        0,  0,  0);                   // 37
    add(1, 0, 0, 0, 0, 0,      0,   0, 0,            0,  0,  0);                   // 38 start
    add(0, 0, 1, 9, 0, 0,      0,   0, 0,            0,  0,  1, 1, 0, 2);          // 39 clrBP slot 2
    add(0, 0, 0, 0, 1, 'h40,   0,   0, 0,            0,  0,  1);                   // 40 no stop
    add(0, 0, 1, 10, 0, 0,     0,   1, 0,            0,  0,  1);                   // 41
    add(0, 0, 1, 7, 0, 0,      0,   1, 32'h1,        0,  0,  1);                   // 42 cause retained
    add(1, 5, 1, 12, 0, 0,     0,   0, 0,            0,  0,  1);                   // 43 unknown type/op
    add(1, 3, 0, 0, 0, 0,      0,   0, 0,            0,  0,  1);                   // 44 step while running
    add(0, 0, 1, 5, 0, 0,      0,   1, 1,            0,  0,  1);                   // 45
    add(1, 2, 0, 0, 0, 0,      0,   0, 0,            1,  1,  1);                   // 46 kill in run
    add(0, 0, 1, 7, 0, 0,      0,   1, 32'h4,        0,  0,  0);                   // 47

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1 expect_out("reset idle", 0, 0, 0, 0, 0);
    step_cycle(); j7valid = 1; opcode = 7;
    #1 expect_out("reset cause", 1, 0, 0, 0, 0);
    step_cycle(); j7valid = 1; opcode = 2;
    #1 expect_out("reset savedPC", 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      apply(tbl[i]);
      #1 expect_out($sformatf("row %0d", i), tbl[i].e_ll, tbl[i].e_lv, tbl[i].e_zpn,
                    tbl[i].e_eaw, tbl[i].e_run);
    end

    // A breakpoint written this cycle must not match until the next one.
    step_cycle(); ctrl_valid = 1; ctrl_type = 0;
    step_cycle(); j7valid = 1; opcode = 8; wdata = 32'h200; wsel = 0; instr_valid = 1; pc = 'h200;
    #1 expect_out("setBP same cycle", 0, 0, 0, 0, 1);
    step_cycle(); instr_valid = 1; pc = 'h200;
    #1 expect_out("setBP next cycle", 0, 0, 1, 0, 1);
    step_cycle(); j7valid = 1; opcode = 7;
    #1 expect_out("setBP cause", 1, 32'hA, 0, 0, 0);

    // Bounded wait for a stop to complete once stopOK rises.
    step_cycle(); ctrl_valid = 1; ctrl_type = 0;
    step_cycle(); ctrl_valid = 1; ctrl_type = 1;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step_cycle(); stop_ok = 1;
      #1 if (zpn) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_bad++;
      $display("FAIL stop wait: zeroPCsetNullify never rose, expected within 8 cycles");
    end
    step_cycle(); j7valid = 1; opcode = 7;
    #1 expect_out("stop wait cause", 1, 32'hB, 0, 0, 0);

    // Reset mid-run clears state, cause and breakpoints.
    step_cycle(); ctrl_valid = 1; ctrl_type = 0;
    step_cycle();
    #1 expect_out("pre-reset run", 0, 0, 0, 0, 1);
    step_cycle(); reset = 1'b1;
    step_cycle(); reset = 1'b0; j7valid = 1; opcode = 10;
    #1 expect_out("post-reset bpEn", 1, 0, 0, 0, 0);
    step_cycle(); j7valid = 1; opcode = 7;
    #1 expect_out("post-reset cause", 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
